// File: rtl/irrigation_scheduler.sv
`default_nettype none
// ============================================================================
// irrigation_scheduler - grants the shared pump to one of three zones and runs
// settle -> pump -> drain -> lockout for each grant.            Revision: 1.0
// ============================================================================
module irrigation_scheduler #(
   parameter int CLK_DIV       = 50000000,
   parameter int TIMER_W       = 16,
   parameter int VALVE_SETTLE  = 2,
   parameter int SPRINKLE_TIME = 600,
   parameter int DRIP_TIME     = 1800,
   parameter int AGRO_TIME     = 300,
   parameter int PUMP_STOP     = 2,
   parameter int LOCKOUT       = 5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       sprinkleReq,
   input  logic       dripReq,
   input  logic       agroReq,
   input  logic       waterLow,
   output logic       pumpOn,
   output logic       sprinkleValve,
   output logic       dripValve,
   output logic       agroValve,
   output logic [1:0] activeZone,
   output logic       busy,
   output logic       cycleDone,
   output logic       dryFault
);

   localparam int PRE_W = $clog2(CLK_DIV);
   localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(CLK_DIV - 1);
   localparam logic [TIMER_W-1:0] T_SETTLE   = TIMER_W'(VALVE_SETTLE);
   localparam logic [TIMER_W-1:0] T_SPRINKLE = TIMER_W'(SPRINKLE_TIME);
   localparam logic [TIMER_W-1:0] T_DRIP     = TIMER_W'(DRIP_TIME);
   localparam logic [TIMER_W-1:0] T_AGRO     = TIMER_W'(AGRO_TIME);
   localparam logic [TIMER_W-1:0] T_STOP     = TIMER_W'(PUMP_STOP);
   localparam logic [TIMER_W-1:0] T_LOCK     = TIMER_W'(LOCKOUT);
   localparam logic [1:0] Z_NONE = 2'd0;
   localparam logic [1:0] Z_SPR  = 2'd1;
   localparam logic [1:0] Z_DRIP = 2'd2;
   localparam logic [1:0] Z_AGRO = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_OPEN = 3'd1,
      S_RUN  = 3'd2,
      S_STOP = 3'd3,
      S_LOCK = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [1:0]           zone_q, zone_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [PRE_W-1:0]     presc_q, presc_d;
   logic                 fair_q, fair_d;
   logic                 aborted_q, aborted_d;
   logic                 dry_d, done_d, valve_d;
   logic                 tick, last_tick, any_req, zone_req, abort;
   logic [1:0]           pick;
   logic [TIMER_W-1:0]   run_time;

   // fair_q=1 means sprinkle was granted last, so drip wins the next tie
   always_comb begin
      any_req = sprinkleReq | dripReq | agroReq;
      if (agroReq)                      pick = Z_AGRO;
      else if (sprinkleReq && dripReq)  pick = fair_q ? Z_DRIP : Z_SPR;
      else if (sprinkleReq)             pick = Z_SPR;
      else                              pick = Z_DRIP;
      case (zone_q)
         Z_SPR:   begin zone_req = sprinkleReq; run_time = T_SPRINKLE; end
         Z_DRIP:  begin zone_req = dripReq;     run_time = T_DRIP;     end
         Z_AGRO:  begin zone_req = agroReq;     run_time = T_AGRO;     end
         default: begin zone_req = 1'b0;        run_time = T_SPRINKLE; end
      endcase
      tick      = (presc_q == PRE_LAST);
      last_tick = tick && (timer_q <= TIMER_W'(1));
      abort     = waterLow | ~enable | ~zone_req;
   end

   always_comb begin
      state_d   = state_q;
      zone_d    = zone_q;
      timer_d   = timer_q;
      fair_d    = fair_q;
      aborted_d = aborted_q;
      dry_d     = dryFault;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (enable && !waterLow && any_req) begin
               state_d   = S_OPEN;
               zone_d    = pick;
               timer_d   = T_SETTLE;
               fair_d    = (pick == Z_SPR);
               aborted_d = 1'b0;
               dry_d     = 1'b0;
            end
         end
         S_OPEN, S_RUN: begin
            if (abort) begin
               state_d   = S_STOP;
               timer_d   = T_STOP;
               aborted_d = 1'b1;
               if (waterLow) dry_d = 1'b1;
            end else if (last_tick) begin
               if (state_q == S_OPEN) begin
                  state_d = S_RUN;
                  timer_d = run_time;
               end else begin
                  state_d = S_STOP;
                  timer_d = T_STOP;
               end
            end else if (tick) begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         S_STOP: begin
            if (last_tick) begin
               state_d = S_LOCK;
               timer_d = T_LOCK;
               zone_d  = Z_NONE;
            end else if (tick) begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         S_LOCK: begin
            if (last_tick) begin
               state_d = S_IDLE;
               timer_d = '0;
               done_d  = ~aborted_q;
            end else if (tick) begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            zone_d  = Z_NONE;
            timer_d = '0;
         end
      endcase
      presc_d = (state_d != state_q || tick || state_q == S_IDLE) ? '0 : presc_q + PRE_W'(1);
      valve_d = (state_d == S_OPEN) || (state_d == S_RUN) || (state_d == S_STOP);
   end

   // Outputs are decoded from the next state so they change on the same edge
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         zone_q        <= Z_NONE;
         timer_q       <= '0;
         presc_q       <= '0;
         fair_q        <= 1'b0;
         aborted_q     <= 1'b0;
         pumpOn        <= 1'b0;
         sprinkleValve <= 1'b0;
         dripValve     <= 1'b0;
         agroValve     <= 1'b0;
         activeZone    <= Z_NONE;
         busy          <= 1'b0;
         cycleDone     <= 1'b0;
         dryFault      <= 1'b0;
      end else begin
         state_q       <= state_d;
         zone_q        <= zone_d;
         timer_q       <= timer_d;
         presc_q       <= presc_d;
         fair_q        <= fair_d;
         aborted_q     <= aborted_d;
         pumpOn        <= (state_d == S_RUN);
         sprinkleValve <= valve_d && (zone_d == Z_SPR);
         dripValve     <= valve_d && (zone_d == Z_DRIP);
         agroValve     <= valve_d && (zone_d == Z_AGRO);
         activeZone    <= zone_d;
         busy          <= (state_d != S_IDLE);
         cycleDone     <= done_d;
         dryFault      <= dry_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_irrigation_scheduler.sv
`default_nettype none
// ============================================================================
// tb_irrigation_scheduler - directed and randomized checks of the scheduler
// against a cycle-count model of the zone schedule.              Revision: 1.0
// ============================================================================
module tb_irrigation_scheduler;

   localparam int CD = 4;
   localparam int VS = 2;
   localparam int ST = 3;
   localparam int DT = 4;
   localparam int AT = 2;
   localparam int PS = 1;
   localparam int LO = 2;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic enable = 1'b0;
   logic sprinkleReq = 1'b0;
   logic dripReq = 1'b0;
   logic agroReq = 1'b0;
   logic waterLow = 1'b0;
   logic pumpOn, sprinkleValve, dripValve, agroValve, busy, cycleDone, dryFault;
   logic [1:0] activeZone;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   irrigation_scheduler #(
      .CLK_DIV(CD), .TIMER_W(8), .VALVE_SETTLE(VS), .SPRINKLE_TIME(ST),
      .DRIP_TIME(DT), .AGRO_TIME(AT), .PUMP_STOP(PS), .LOCKOUT(LO)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .sprinkleReq(sprinkleReq), .dripReq(dripReq), .agroReq(agroReq),
      .waterLow(waterLow), .pumpOn(pumpOn), .sprinkleValve(sprinkleValve),
      .dripValve(dripValve), .agroValve(agroValve), .activeZone(activeZone),
      .busy(busy), .cycleDone(cycleDone), .dryFault(dryFault)
   );

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic int run_cycles(input logic [1:0] z);
      case (z)
         2'd1:    return ST * CD;
         2'd2:    return DT * CD;
         default: return AT * CD;
      endcase
   endfunction

   // Model: phase 0 idle, 1 open, 2 run, 3 stop, 4 lock; durations in clock cycles
   int         m_ph, m_left;
   logic [1:0] m_zone;
   logic       m_next_drip, m_abort, m_dry, m_done;

   always @(posedge clock or negedge reset) begin : model
      int ph, lf;
      logic [1:0] z;
      logic nd, ab, dr, dn, zreq;
      if (!reset) begin
         m_ph <= 0; m_left <= 0; m_zone <= 2'd0;
         m_next_drip <= 1'b0; m_abort <= 1'b0; m_dry <= 1'b0; m_done <= 1'b0;
      end else begin
         ph = m_ph; lf = m_left; z = m_zone; nd = m_next_drip;
         ab = m_abort; dr = m_dry; dn = 1'b0;
         zreq = (z == 2'd1) ? sprinkleReq : (z == 2'd2) ? dripReq : agroReq;
         case (ph)
            0: if (enable && !waterLow && (sprinkleReq || dripReq || agroReq)) begin
                  if (agroReq)                     z = 2'd3;
                  else if (sprinkleReq && dripReq) z = nd ? 2'd2 : 2'd1;
                  else if (sprinkleReq)            z = 2'd1;
                  else                             z = 2'd2;
                  nd = (z == 2'd1);
                  ph = 1; lf = VS * CD; ab = 1'b0; dr = 1'b0;
               end
            1, 2: if (waterLow || !enable || !zreq) begin
                  ph = 3; lf = PS * CD; ab = 1'b1;
                  if (waterLow) dr = 1'b1;
               end else begin
                  lf--;
                  if (lf == 0) begin
                     if (ph == 1) begin ph = 2; lf = run_cycles(z); end
                     else         begin ph = 3; lf = PS * CD;       end
                  end
               end
            3: begin
                  lf--;
                  if (lf == 0) begin ph = 4; lf = LO * CD; z = 2'd0; end
               end
            default: begin
                  lf--;
                  if (lf == 0) begin ph = 0; dn = !ab; end
               end
         endcase
         m_ph <= ph; m_left <= lf; m_zone <= z; m_next_drip <= nd;
         m_abort <= ab; m_dry <= dr; m_done <= dn;
      end
   end

   logic [9:0] dut_v, exp_v;
   assign dut_v = {pumpOn, sprinkleValve, dripValve, agroValve, activeZone, busy, cycleDone, dryFault};
   assign exp_v = {m_ph == 2,
                   (m_ph >= 1 && m_ph <= 3 && m_zone == 2'd1),
                   (m_ph >= 1 && m_ph <= 3 && m_zone == 2'd2),
                   (m_ph >= 1 && m_ph <= 3 && m_zone == 2'd3),
                   m_zone, m_ph != 0, m_done, m_dry};

   always @(posedge clock) begin
      #1;
      check("cycle_outputs", 32'(dut_v), 32'(exp_v));
   end

   logic [1:0] gz [3];
   logic [1:0] prevz;
   int ng, ndone;
   logic pump_seen, done_seen;

   initial begin
      // Reset and a plain sprinkle run
      step(); step();
      check("reset_state", 32'(dut_v), 32'd0);
      reset = 1'b1;
      step();
      enable = 1'b1; sprinkleReq = 1'b1;
      step();                               // grant edge = cycle 0
      check("t1_valve_at_grant", 32'(sprinkleValve), 32'd1);
      check("t1_zone_at_grant", 32'(activeZone), 32'd1);
      check("t1_pump_at_grant", 32'(pumpOn), 32'd0);
      repeat (7) step();
      check("t1_pump_c7", 32'(pumpOn), 32'd0);
      step();
      check("t1_pump_c8", 32'(pumpOn), 32'd1);
      repeat (11) step();
      check("t1_pump_c19", 32'(pumpOn), 32'd1);
      step();
      check("t1_pump_c20", 32'(pumpOn), 32'd0);
      check("t1_valve_c20", 32'(sprinkleValve), 32'd1);
      sprinkleReq = 1'b0;
      repeat (4) step();
      check("t1_valve_c24", 32'(sprinkleValve), 32'd0);
      check("t1_busy_c24", 32'(busy), 32'd1);
      check("t1_zone_c24", 32'(activeZone), 32'd0);
      repeat (8) step();
      check("t1_done_c32", 32'(cycleDone), 32'd1);
      check("t1_busy_c32", 32'(busy), 32'd0);
      step();
      check("t1_done_c33", 32'(cycleDone), 32'd0);

      // waterLow abort mid-run
      sprinkleReq = 1'b1;
      step();
      repeat (12) step();
      waterLow = 1'b1;
      step();
      check("t4_pump_off", 32'(pumpOn), 32'd0);
      check("t4_valve_drain", 32'(sprinkleValve), 32'd1);
      check("t4_dry_set", 32'(dryFault), 32'd1);
      repeat (3) step();
      check("t4_valve_c16", 32'(sprinkleValve), 32'd1);
      step();
      check("t4_valve_c17", 32'(sprinkleValve), 32'd0);
      repeat (8) step();
      check("t4_idle", 32'(busy), 32'd0);
      check("t4_no_done", 32'(cycleDone), 32'd0);
      repeat (10) step();
      check("t4_no_grant_dry", 32'(busy), 32'd0);
      waterLow = 1'b0;
      step();
      check("t4_regrant", 32'(busy), 32'd1);
      check("t4_dry_cleared", 32'(dryFault), 32'd0);
      sprinkleReq = 1'b0;
      repeat (14) step();
      check("t4_drained", 32'(busy), 32'd0);

      // enable gating
      enable = 1'b0; sprinkleReq = 1'b1;
      repeat (6) step();
      check("t6_no_grant", 32'(busy), 32'd0);
      enable = 1'b1;
      step();
      check("t6_grant", 32'(busy), 32'd1);
      repeat (2) step();
      enable = 1'b0;
      pump_seen = 1'b0; done_seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         pump_seen |= pumpOn;
         done_seen |= cycleDone;
      end
      check("t6_pump_never", 32'(pump_seen), 32'd0);
      check("t6_no_done", 32'(done_seen), 32'd0);
      check("t6_idle", 32'(busy), 32'd0);
      sprinkleReq = 1'b0; enable = 1'b1;
      step();

      // agro priority, drip follows right after lockout
      agroReq = 1'b1; dripReq = 1'b1;
      step();
      check("t2_agro_first", 32'(activeZone), 32'd3);
      check("t2_agro_valve", 32'(agroValve), 32'd1);
      repeat (21) step();
      agroReq = 1'b0;
      repeat (7) step();
      check("t2_agro_done", 32'(cycleDone), 32'd1);
      check("t2_drip_not_yet", 32'(dripValve), 32'd0);
      step();
      check("t2_drip_valve", 32'(dripValve), 32'd1);
      check("t2_drip_zone", 32'(activeZone), 32'd2);
      dripReq = 1'b0;
      repeat (14) step();

      // async reset mid-run
      sprinkleReq = 1'b1;
      step();
      repeat (10) step();
      check("t5_in_run", 32'(pumpOn), 32'd1);
      #2 reset = 1'b0;
      #1 check("t5_async_clear", 32'(dut_v), 32'd0);
      sprinkleReq = 1'b0;
      step(); step();
      reset = 1'b1;
      step();
      check("t5_idle_after", 32'(busy), 32'd0);

      // sprinkle/drip alternation from reset fairness
      sprinkleReq = 1'b1; dripReq = 1'b1;
      prevz = 2'd0; ng = 0; ndone = 0;
      for (int k = 0; k < 3; k++) gz[k] = 2'd0;
      for (int c = 0; c < 200 && ng < 3; c++) begin
         step();
         if (activeZone != 2'd0 && prevz == 2'd0) begin
            gz[ng] = activeZone;
            ng++;
         end
         if (cycleDone) ndone++;
         prevz = activeZone;
      end
      check("t3_grant_count", 32'(ng), 32'd3);
      check("t3_first", 32'(gz[0]), 32'd1);
      check("t3_second", 32'(gz[1]), 32'd2);
      check("t3_third", 32'(gz[2]), 32'd1);
      check("t3_done_count", 32'(ndone), 32'd2);
      sprinkleReq = 1'b0; dripReq = 1'b0;
      repeat (14) step();

      // randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) sprinkleReq = ~sprinkleReq;
         if ($urandom_range(0, 39) == 0) dripReq = ~dripReq;
         if ($urandom_range(0, 79) == 0) agroReq = ~agroReq;
         enable   = ($urandom_range(0, 149) != 0);
         waterLow = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 1499) == 0) begin
            #1 reset = 1'b0;
            #2 reset = 1'b1;
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
